// File: rtl/pipeline_reg_skid.sv
// EX->MEM/WB pipeline register with an optional two-entry skid buffer.
// SKID=1: in_ready depends only on registered state, so back-pressure never
// forms a combinational path from out_ready to in_ready.
// SKID=0: a single register whose in_ready follows out_ready in the same cycle.
module pipeline_reg_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_wr_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wr_tag,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_result_q, main_result_d;
    logic [REG_W-1:0]  main_rd_q, main_rd_d;
    logic              main_tag_q, main_tag_d;
    logic [DATA_W-1:0] skid_result_q, skid_result_d;
    logic [REG_W-1:0]  skid_rd_q, skid_rd_d;
    logic              skid_tag_q, skid_tag_d;

    logic push, pop;

    // Handshake and output decode; main register always feeds the outputs.
    always_comb begin
        out_valid = (state_q != StEmpty);
        if (SKID != 0) begin
            in_ready = !rst && (state_q != StFull);
        end else begin
            in_ready = !rst && (!out_valid || out_ready);
        end
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        out_result = main_result_q;
        out_rd     = main_rd_q;
        out_wr_tag = main_tag_q && out_valid;
        unique case (state_q)
            StOne:   occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Next-state and data routing. With SKID=0 a push while ONE implies a pop,
    // so StFull is unreachable and the same transition table serves both modes.
    always_comb begin
        state_d       = state_q;
        main_result_d = main_result_q;
        main_rd_d     = main_rd_q;
        main_tag_d    = main_tag_q;
        skid_result_d = skid_result_q;
        skid_rd_d     = skid_rd_q;
        skid_tag_d    = skid_tag_q;
        if (flush) begin
            // Valid state only; data registers keep their last contents.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d       = StOne;
                        main_result_d = in_result;
                        main_rd_d     = in_rd;
                        main_tag_d    = in_wr_tag;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_result_d = in_result;
                        main_rd_d     = in_rd;
                        main_tag_d    = in_wr_tag;
                    end else if (push) begin
                        state_d       = StFull;
                        skid_result_d = in_result;
                        skid_rd_d     = in_rd;
                        skid_tag_d    = in_wr_tag;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_d       = StOne;
                        main_result_d = skid_result_q;
                        main_rd_d     = skid_rd_q;
                        main_tag_d    = skid_tag_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State and data registers, cleared asynchronously so outputs read zero in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StEmpty;
            main_result_q <= '0;
            main_rd_q     <= '0;
            main_tag_q    <= 1'b0;
            skid_result_q <= '0;
            skid_rd_q     <= '0;
            skid_tag_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            main_result_q <= main_result_d;
            main_rd_q     <= main_rd_d;
            main_tag_q    <= main_tag_d;
            skid_result_q <= skid_result_d;
            skid_rd_q     <= skid_rd_d;
            skid_tag_q    <= skid_tag_d;
        end
    end

endmodule

// File: tb/tb_pipeline_reg_skid.sv
// Bench for pipeline_reg_skid: a skid instance driven by a vector table plus
// hand sequences, and a plain-register instance; scoreboards track ordering.
module tb_pipeline_reg_skid;

    logic clk = 1'b0;
    logic rst;

    // Skid instance signals
    logic        flush, in_valid, in_ready, in_wr_tag, out_valid, out_ready, out_wr_tag;
    logic [31:0] in_result, out_result;
    logic [4:0]  in_rd, out_rd;
    logic [1:0]  occupancy;

    // Plain instance signals
    logic        p_flush, p_in_valid, p_in_ready, p_in_wr_tag, p_out_valid, p_out_ready;
    logic        p_out_wr_tag;
    logic [31:0] p_in_result, p_out_result;
    logic [4:0]  p_in_rd, p_out_rd;
    logic [1:0]  p_occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        tag;
    } ent_t;

    typedef struct {
        logic        fl, iv;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        tag, ordy;
        logic        e_ir, e_ov;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        logic        e_tag;
        logic [1:0]  e_occ;
    } vec_t;

    ent_t sq[$];
    ent_t pq[$];
    ent_t sb_e, pb_e;
    vec_t vecs[15];

    pipeline_reg_skid #(.DATA_W(32), .REG_W(5), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_rd(in_rd), .in_wr_tag(in_wr_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wr_tag(out_wr_tag),
        .occupancy(occupancy)
    );

    pipeline_reg_skid #(.DATA_W(32), .REG_W(5), .SKID(0)) u_plain (
        .clk(clk), .rst(rst), .flush(p_flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_result(p_in_result), .in_rd(p_in_rd), .in_wr_tag(p_in_wr_tag),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_result(p_out_result), .out_rd(p_out_rd), .out_wr_tag(p_out_wr_tag),
        .occupancy(p_occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Skid scoreboard: pop compares the oldest accepted entry, then push appends.
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            sq.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_skid: unexpected entry 0x%0h, queue empty", out_result);
                end else begin
                    sb_e = sq.pop_front();
                    if ({out_result, out_rd, out_wr_tag} !== sb_e) begin
                        errors++;
                        $display("FAIL sb_skid: got %0h/%0d/%0b expected %0h/%0d/%0b",
                                 out_result, out_rd, out_wr_tag, sb_e.res, sb_e.rd, sb_e.tag);
                    end
                end
            end
            if (in_valid && in_ready) sq.push_back({in_result, in_rd, in_wr_tag});
        end
    end

    // Plain scoreboard
    always @(posedge clk or posedge rst) begin
        if (rst || p_flush) begin
            pq.delete();
        end else begin
            if (p_out_valid && p_out_ready) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_plain: unexpected entry 0x%0h, queue empty", p_out_result);
                end else begin
                    pb_e = pq.pop_front();
                    if ({p_out_result, p_out_rd, p_out_wr_tag} !== pb_e) begin
                        errors++;
                        $display("FAIL sb_plain: got %0h/%0d/%0b expected %0h/%0d/%0b",
                                 p_out_result, p_out_rd, p_out_wr_tag, pb_e.res, pb_e.rd,
                                 pb_e.tag);
                    end
                end
            end
            if (p_in_valid && p_in_ready) pq.push_back({p_in_result, p_in_rd, p_in_wr_tag});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          fl iv res       rd tg ordy | ir ov res       rd tg occ
        vecs[0]  = '{0, 1, 32'h1234, 7, 1, 1,    1, 1, 32'h1234, 7, 1, 1};
        vecs[1]  = '{0, 0, 32'h0,    0, 0, 1,    1, 0, 32'h1234, 7, 0, 0};
        vecs[2]  = '{0, 1, 32'h11,   1, 0, 0,    1, 1, 32'h11,   1, 0, 1};
        vecs[3]  = '{0, 1, 32'h22,   2, 1, 0,    0, 1, 32'h11,   1, 0, 2};
        vecs[4]  = '{0, 1, 32'h99,   3, 1, 0,    0, 1, 32'h11,   1, 0, 2};
        vecs[5]  = '{0, 0, 32'h0,    0, 0, 1,    1, 1, 32'h22,   2, 1, 1};
        vecs[6]  = '{0, 0, 32'h0,    0, 0, 1,    1, 0, 32'h22,   2, 0, 0};
        vecs[7]  = '{0, 1, 32'h44,   4, 1, 0,    1, 1, 32'h44,   4, 1, 1};
        vecs[8]  = '{0, 1, 32'h33,   5, 0, 1,    1, 1, 32'h33,   5, 0, 1};
        vecs[9]  = '{0, 1, 32'h55,   6, 1, 0,    0, 1, 32'h33,   5, 0, 2};
        vecs[10] = '{1, 1, 32'h66,   8, 1, 1,    1, 0, 32'h33,   5, 0, 0};
        vecs[11] = '{0, 0, 32'h0,    0, 0, 1,    1, 0, 32'h33,   5, 0, 0};
        vecs[12] = '{0, 1, 32'h77,   9, 0, 1,    1, 1, 32'h77,   9, 0, 1};
        vecs[13] = '{0, 0, 32'h0,    0, 0, 0,    1, 1, 32'h77,   9, 0, 1};
        vecs[14] = '{1, 0, 32'h0,    0, 0, 0,    1, 0, 32'h77,   9, 0, 0};

        flush = 0; in_valid = 0; in_result = 0; in_rd = 0; in_wr_tag = 0; out_ready = 0;
        p_flush = 0; p_in_valid = 0; p_in_result = 0; p_in_rd = 0; p_in_wr_tag = 0;
        p_out_ready = 0;
        rst = 1;
        #12;
        chk("rst_ir", {31'b0, in_ready}, 0);
        chk("rst_ov", {31'b0, out_valid}, 0);
        chk("rst_res", out_result, 0);
        chk("rst_occ", {30'b0, occupancy}, 0);
        chk("rst_p_ir", {31'b0, p_in_ready}, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("post_rst_ir", {31'b0, in_ready}, 1);

        // Table-driven sequence on the skid instance
        for (int i = 0; i < 15; i++) begin
            flush = vecs[i].fl; in_valid = vecs[i].iv; in_result = vecs[i].res;
            in_rd = vecs[i].rd; in_wr_tag = vecs[i].tag; out_ready = vecs[i].ordy;
            step();
            chk($sformatf("v%0d_ir", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
            chk($sformatf("v%0d_ov", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            chk($sformatf("v%0d_res", i), out_result, vecs[i].e_res);
            chk($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].e_rd});
            chk($sformatf("v%0d_tag", i), {31'b0, out_wr_tag}, {31'b0, vecs[i].e_tag});
            chk($sformatf("v%0d_occ", i), {30'b0, occupancy}, {30'b0, vecs[i].e_occ});
        end
        flush = 0;

        // Asynchronous reset while FULL
        in_valid = 1; in_result = 32'hA1; in_rd = 1; in_wr_tag = 1; out_ready = 0;
        step();
        in_result = 32'hA2; in_rd = 2;
        step();
        chk("full_occ", {30'b0, occupancy}, 2);
        in_valid = 0;
        #3;
        rst = 1;
        #1;
        chk("arst_ov", {31'b0, out_valid}, 0);
        chk("arst_res", out_result, 0);
        chk("arst_rd", {27'b0, out_rd}, 0);
        chk("arst_tag", {31'b0, out_wr_tag}, 0);
        chk("arst_occ", {30'b0, occupancy}, 0);
        chk("arst_ir", {31'b0, in_ready}, 0);
        @(negedge clk);
        rst = 0;
        in_valid = 1; in_result = 32'hAB; in_rd = 10; in_wr_tag = 1; out_ready = 0;
        #1;
        chk("rel_ir", {31'b0, in_ready}, 1);
        step();
        chk("rel_ov", {31'b0, out_valid}, 1);
        chk("rel_res", out_result, 32'hAB);
        chk("rel_occ", {30'b0, occupancy}, 1);
        in_valid = 0; out_ready = 1;
        step();
        chk("drain_ov", {31'b0, out_valid}, 0);
        chk("skid_queue_empty", sq.size(), 0);
        out_ready = 0;

        // Plain register instance
        p_in_valid = 1; p_in_result = 32'h10; p_in_rd = 1; p_in_wr_tag = 1; p_out_ready = 0;
        step();
        chk("p_held_ov", {31'b0, p_out_valid}, 1);
        chk("p_held_res", p_out_result, 32'h10);
        chk("p_held_occ", {30'b0, p_occupancy}, 1);
        chk("p_held_ir", {31'b0, p_in_ready}, 0);
        p_in_result = 32'h30; p_in_rd = 3;
        step();
        chk("p_stall_res", p_out_result, 32'h10);
        chk("p_stall_occ", {30'b0, p_occupancy}, 1);
        p_in_result = 32'h20; p_in_rd = 2; p_in_wr_tag = 0; p_out_ready = 1;
        #1;
        chk("p_pass_ir", {31'b0, p_in_ready}, 1);
        step();
        chk("p_pass_ov", {31'b0, p_out_valid}, 1);
        chk("p_pass_res", p_out_result, 32'h20);
        chk("p_pass_rd", {27'b0, p_out_rd}, 2);
        chk("p_pass_tag", {31'b0, p_out_wr_tag}, 0);
        chk("p_pass_occ", {30'b0, p_occupancy}, 1);
        p_in_valid = 0;
        step();
        chk("p_drain_ov", {31'b0, p_out_valid}, 0);
        chk("p_drain_occ", {30'b0, p_occupancy}, 0);
        chk("plain_queue_empty", pq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
